seq_mult: RTL and testbench
===========================

Name: seq_mult

Overview:
Parametrised sequential shift-and-add unsigned multiplier. Successor to the fixed 3x3 combinational array multiplier on the board top level.
- Operands come from the button-memory outputs.
- The product drives the LEDs and the LCD driver.
- Trades array area for WIDTH cycles of latency, using a start/busy/done handshake.

Parameters:
WIDTH, 3, operand width in bits (legal range 2..16); product is 2*WIDTH bits.

Ports:
clk      input   1          system clock, rising edge
reset    input   1          synchronous, active-low reset (sampled on rising clk edge, 0 = reset)
start    input   1          request a multiply; sampled only in IDLE
a        input   WIDTH      multiplicand, unsigned, captured on accepted start
b        input   WIDTH      multiplier, unsigned, captured on accepted start
acc_clr  input   1          accumulator clear, sampled with accepted start (used only with SEQ_MULT_ACC_EN)
busy     output  1          high whenever state != IDLE
done     output  1          one-cycle pulse: product just updated
product  output  2*WIDTH    last completed result, held until next completion
ovf      output  1          sticky accumulate overflow (used only with SEQ_MULT_ACC_EN)

Behaviour:
- Reset (reset==0 at a clk edge, in any state, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, product=0, ovf=0.
  - Internal multiplicand, multiplier, partial sum and bit counter are cleared.
  - An aborted operation never produces done.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1 at edge k, latch a into the multiplicand register (zero-extended to 2*WIDTH), latch b into the multiplier register, clear the partial sum, set counter=0, and go to RUN. Otherwise stay in IDLE.
  - RUN, each edge:
    - If multiplier[0]=1: partial += multiplicand.
    - multiplicand <<= 1; multiplier >>= 1; counter++.
    - After the edge where counter reaches WIDTH (edge k+WIDTH): product <= final sum, state goes to DONE.
  - DONE: done=1 for exactly this one cycle; next edge returns to IDLE.
- Latency:
  - An accepted start at edge k gives done high in the cycle following edge k+WIDTH.
  - busy is high in the cycles following edges k..k+WIDTH.
  - Next start can be accepted at edge k+WIDTH+1, i.e. the edge leaving DONE, while IDLE-bound: no.
  - Start is only acted on when the sampled state is IDLE, so the earliest next accept is edge k+WIDTH+2.
- Handshake:
  - start while busy=1 (RUN or DONE) is ignored, not queued.
  - a, b and acc_clr may change freely after the accepting edge.
- Arithmetic:
  - Partial sum is 2*WIDTH bits; the unsigned product cannot overflow.
  - Fixed latency regardless of operand values; zero operands give no early exit.
- Outputs are registered, with no combinational path from inputs to outputs.
- product changes only on the DONE-entry edge or on reset.

Optional Feature:
SEQ_MULT_ACC_EN
- Defined (multiply-accumulate):
  - On an accepted start, the partial sum is initialised to 0 if acc_clr=1, otherwise to the current product.
  - product = base + a*b, modulo 2^(2*WIDTH).
  - ovf is set on the DONE-entry edge if the addition carried out of bit 2*WIDTH-1.
  - ovf is cleared only by reset or by an accepted start with acc_clr=1.
- Undefined:
  - acc_clr is ignored; the partial sum always starts at 0.
  - ovf is tied to 0.
  - No accumulate hardware is generated.

Test Plan:
1. WIDTH=3, reset low for 2 edges, then high, a=7, b=7, start pulse at edge k -> busy=1 from k; done=1 exactly in the cycle after edge k+3; product=49 (6'b110001); busy=0 after edge k+4.
2. WIDTH=3, a=5, b=0 then a=0, b=6, back-to-back starts each at the earliest legal edge (k+WIDTH+2) -> both complete with product=0; latency 3 each; exactly one done pulse each.
3. WIDTH=3, a=3, b=2 start; during RUN drive start=1 with a=7, b=7 every cycle -> only one done; product=6; second request not executed until start is sampled in IDLE.
4. WIDTH=3, start a=6, b=5; assert reset low at edge k+2 (mid-RUN) -> no done pulse; product=0, busy=0 next cycle; a subsequent start with a=6, b=5 yields 30.
5. WIDTH=8 build: a=255, b=255 -> product=65025 (16'hFE01), done in the cycle after edge k+8; a=128, b=2 -> 256.
6. SEQ_MULT_ACC_EN, WIDTH=3:
   - start with acc_clr=1, a=7, b=7 -> product=49, ovf=0.
   - start with acc_clr=0, a=7, b=7 -> product=34 (98 mod 64), ovf=1.
   - start with acc_clr=0, a=1, b=1 -> product=35, ovf remains 1.
   - start with acc_clr=1, a=2, b=3 -> product=6, ovf=0.

Source files
------------

// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - sequential shift-and-add unsigned multiplier with start/busy/done handshake
// Optional multiply-accumulate mode enabled by defining SEQ_MULT_ACC_EN.
module seq_mult #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               acc_clr,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   partial_q, partial_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   sum;
  logic [PW-1:0]   base;

`ifdef SEQ_MULT_ACC_EN
  logic            ovf_q, ovf_d;
  logic            carry_q, carry_d;
  logic            add_carry;

  // At most one carry can occur over a whole accumulate, so it is simply OR-ed up.
  assign {add_carry, sum} = {1'b0, partial_q} + {1'b0, addend};
  assign base = acc_clr ? '0 : product_q;
`else
  logic            unused_acc_clr;

  assign unused_acc_clr = acc_clr;
  assign sum  = partial_q + addend;
  assign base = '0;
`endif

  assign addend = mplier_q[0] ? mcand_q : '0;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
`ifdef SEQ_MULT_ACC_EN
    ovf_d     = ovf_q;
    carry_d   = carry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d   = {{WIDTH{1'b0}}, a};
          mplier_d  = b;
          partial_d = base;
          cnt_d     = '0;
          state_d   = S_RUN;
`ifdef SEQ_MULT_ACC_EN
          carry_d   = 1'b0;
          if (acc_clr) ovf_d = 1'b0;
`endif
        end
      end
      S_RUN: begin
        partial_d = sum;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        cnt_d     = cnt_q + CW'(1);
`ifdef SEQ_MULT_ACC_EN
        carry_d   = carry_q | add_carry;
`endif
        if (cnt_q == LAST) begin
          product_d = sum;
          done_d    = 1'b1;
          state_d   = S_DONE;
`ifdef SEQ_MULT_ACC_EN
          ovf_d     = ovf_q | carry_q | add_carry;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_MULT_ACC_EN
      ovf_q     <= 1'b0;
      carry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SEQ_MULT_ACC_EN
      ovf_q     <= ovf_d;
      carry_q   <= carry_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
`ifdef SEQ_MULT_ACC_EN
  assign ovf     = ovf_q;
`else
  assign ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_seq_mult.sv
// tb/tb_seq_mult.sv - scoreboard bench for seq_mult at WIDTH=3 and WIDTH=8
module tb_seq_mult;

`ifdef SEQ_MULT_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  typedef struct {
    logic [15:0] prod;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic       start3 = 1'b0, clr3 = 1'b1, busy3, done3, ovf3;
  logic [2:0] a3 = '0, b3 = '0;
  logic [5:0] product3;

  logic       start8 = 1'b0, clr8 = 1'b1, busy8, done8, ovf8;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] product8;

  exp_t q3[$];
  exp_t q8[$];

  seq_mult #(.WIDTH(3)) dut3 (
    .clk(clk), .reset(rstn), .start(start3), .a(a3), .b(b3), .acc_clr(clr3),
    .busy(busy3), .done(done3), .product(product3), .ovf(ovf3)
  );

  seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rstn), .start(start8), .a(a8), .b(b8), .acc_clr(clr8),
    .busy(busy8), .done(done8), .product(product8), .ovf(ovf8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done3) begin
      if (q3.size() == 0) begin
        check("done3_unexpected", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        check("product3", {10'd0, product3}, e.prod);
        check("ovf3", {15'd0, ovf3}, {15'd0, e.ovf});
        check("latency3", 16'(cyc), 16'(e.cyc));
      end
    end
    if (done8) begin
      if (q8.size() == 0) begin
        check("done8_unexpected", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("product8", product8, e.prod);
        check("ovf8", {15'd0, ovf8}, {15'd0, e.ovf});
        check("latency8", 16'(cyc), 16'(e.cyc));
      end
    end
  end

  task automatic issue3(input logic [2:0] ia, input logic [2:0] ib, input logic clr,
                        input logic [5:0] ep, input logic eo, input bit push);
    int n = 0;
    while (busy3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy3) check("idle_wait3", 16'd1, 16'd0);
    a3 = ia; b3 = ib; clr3 = clr; start3 = 1'b1;
    if (push) q3.push_back('{prod: {10'd0, ep}, ovf: eo, cyc: cyc + 1 + 3});
    @(negedge clk);
    start3 = 1'b0;
    check("busy3_after_start", {15'd0, busy3}, 16'd1);
  endtask

  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] ep);
    int n = 0;
    while (busy8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy8) check("idle_wait8", 16'd1, 16'd0);
    a8 = ia; b8 = ib; clr8 = 1'b1; start8 = 1'b1;
    q8.push_back('{prod: ep, ovf: 1'b0, cyc: cyc + 1 + 8});
    @(negedge clk);
    start8 = 1'b0;
    check("busy8_after_start", {15'd0, busy8}, 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {15'd0, busy3}, 16'd0);
    check("rst_done", {15'd0, done3}, 16'd0);
    check("rst_product", {10'd0, product3}, 16'd0);
    check("rst_ovf", {15'd0, ovf3}, 16'd0);
    rstn = 1'b1;
    @(negedge clk);

    // 7*7 with explicit busy window check
    issue3(3'd7, 3'd7, 1'b1, 6'd49, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("busy3_in_done", {15'd0, busy3}, 16'd1);
    @(negedge clk);
    check("busy3_after_done", {15'd0, busy3}, 16'd0);

    // Zero operands, back-to-back at the earliest legal accept edge
    issue3(3'd5, 3'd0, 1'b1, 6'd0, 1'b0, 1'b1);
    issue3(3'd0, 3'd6, 1'b1, 6'd0, 1'b0, 1'b1);

    // Start held during RUN must be ignored
    issue3(3'd3, 3'd2, 1'b1, 6'd6, 1'b0, 1'b1);
    a3 = 3'd7; b3 = 3'd7; start3 = 1'b1;
    repeat (3) @(negedge clk);
    start3 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("busy3_no_requeue", {15'd0, busy3}, 16'd0);
    end

    // Reset mid-RUN aborts without done
    issue3(3'd6, 3'd5, 1'b1, 6'd0, 1'b0, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_busy", {15'd0, busy3}, 16'd0);
    check("abort_product", {10'd0, product3}, 16'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    issue3(3'd6, 3'd5, 1'b1, 6'd30, 1'b0, 1'b1);

    // Accumulate sequence; plain multiply results when the feature is absent
    issue3(3'd7, 3'd7, 1'b1, 6'd49, 1'b0, 1'b1);
    issue3(3'd7, 3'd7, 1'b0, ACC ? 6'd34 : 6'd49, ACC, 1'b1);
    issue3(3'd1, 3'd1, 1'b0, ACC ? 6'd35 : 6'd1, ACC, 1'b1);
    issue3(3'd2, 3'd3, 1'b1, 6'd6, 1'b0, 1'b1);

    // WIDTH=8 instance
    issue8(8'd255, 8'd255, 16'hFE01);
    issue8(8'd128, 8'd2, 16'd256);
    issue8(8'd0, 8'd200, 16'd0);

    repeat (20) @(negedge clk);
    check("q3_drained", 16'(q3.size()), 16'd0);
    check("q8_drained", 16'(q8.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
